axi4_lite_master: RTL
=====================

# axi4_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI4-Lite write and read transactions. It drives the register slaves in the programmable-logic fabric, for example the LED control/status register bank, from local logic such as a button-driven sequencer or a test stimulus block, without going through the PS. It issues one transaction at a time and returns the slave's response and read data on a registered response port.

## Interface
- AXI_DATA_WIDTH_C, 32, data width of AXI bus and command/response data (32 or 64)
- AXI_ADDR_WIDTH_C, 7, address width
- clk  in  1  sole clock; all ports synchronous to it
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH_C  byte address
- cmd_wdata  in  AXI_DATA_WIDTH_C  write data (ignored for reads)
- cmd_wstrb  in  AXI_DATA_WIDTH_C/8  write strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  AXI_DATA_WIDTH_C  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP from the slave
- awaddr/awprot/awvalid out, awready in: write address channel (awprot width 3)
- wdata/wstrb/wvalid out, wready in: write data channel
- bresp in (2), bvalid in, bready out: write response channel
- araddr/arprot/arvalid out, arready in: read address channel (arprot width 3)
- rdata in, rresp in (2), rvalid in, rready out: read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, register addr, wdata, wstrb and the write flag, then go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: awvalid and wvalid are both asserted in the first WR_REQ cycle. Each channel deasserts independently on its own handshake. Per-channel "done" flags track completion. The FSM leaves for WR_RESP in the cycle after both are done; a same-cycle double handshake leaves after one cycle.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_write=1, rsp_rdata=0, and go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, set rsp_write=0, and go to RSP.
- RSP: rsp_valid=1 with all rsp_* held stable until rsp_ready, then go to IDLE.
- awaddr/araddr/wdata/wstrb hold the registered command values; they are stable while the related valid is high.
- awprot and arprot are tied to 3'b000.
- No transaction is abandoned and there is no timeout. A slave that never responds leaves the block in WR_RESP or RD_DATA.
- bresp/rresp are passed through unmodified; SLVERR and DECERR are not treated specially.

## Timing
- Reset values:
  - cmd_ready=0 during reset, 1 in the first cycle after reset release (IDLE).
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0.
  - awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0.
  - awaddr, araddr, wdata, wstrb = 0.
- All AXI and rsp outputs are driven from flops. cmd_ready is decoded from the state register.
- Write latency with an always-ready slave, counting cycle 0 as the cmd accept:
  - aw/w handshake in cycle 1;
  - bready=1 from cycle 2; bvalid in cycle 2 means rsp_valid in cycle 3.
  - Minimum 3 cycles.
- Read latency: ar handshake in cycle 1, rready from cycle 2, rsp_valid in cycle 3 at the earliest.
- Valid signals never drop before their handshake.
- No new command is accepted until the response is consumed. Throughput is at most one transaction per 4 cycles.
- rst asserted mid-transaction returns to IDLE immediately and deasserts every valid/ready asynchronously. The in-flight response is discarded.

## Test plan
- Write addr 0x00, data 0x0000_0001, wstrb 0xF, slave always ready, BRESP=OKAY -> one aw and one w handshake, each with awaddr 0x00; rsp_valid in cycle 3 with rsp_write=1 and rsp_resp=2'b00.
- Slave holds awready low 5 cycles and wready low 2 cycles -> w handshake first; wvalid drops while awvalid stays high with stable awaddr; bready rises the cycle after the aw handshake.
- Read addr 0x04, slave returns rdata 0x0000_002A and RRESP=OKAY after 3 idle cycles with rvalid low -> rsp_rdata 0x2A, rsp_write=0, rsp_resp=0.
- Read with RRESP=SLVERR (2'b10) and rsp_ready held low for 4 cycles -> rsp_valid with resp 2'b10 stays stable for those 4 cycles; cmd_ready stays 0 until the cycle after rsp_ready.
- Back-to-back commands with cmd_valid held high (write then read) -> second command is accepted only in the cycle after the first response handshake; no overlap on AXI channels.
- rst pulsed while in WR_RESP -> all valids/readies are 0 asynchronously; after release, cmd_ready=1 and no rsp_valid is produced for the aborted write.

Source files
------------

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: converts a cmd/rsp handshake into one
// AXI4-Lite write or read at a time, returning the slave response on a registered port.
module axi4_lite_master #(
  parameter int AXI_DATA_WIDTH_C = 32,
  parameter int AXI_ADDR_WIDTH_C = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH_C-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH_C-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH_C/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI_DATA_WIDTH_C-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [AXI_ADDR_WIDTH_C-1:0]   awaddr,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [AXI_DATA_WIDTH_C-1:0]   wdata,
  output logic [AXI_DATA_WIDTH_C/8-1:0] wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [AXI_ADDR_WIDTH_C-1:0]   araddr,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [AXI_DATA_WIDTH_C-1:0]   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam int STRB_W = AXI_DATA_WIDTH_C / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH_C-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH_C-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]           wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_write_q, rsp_write_d;
  logic [AXI_DATA_WIDTH_C-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;

  logic cmd_acc, aw_hs, w_hs, wr_req_done;

  // Gated by rst so no command can be taken while reset is held.
  assign cmd_ready   = (state_q == S_IDLE) & ~rst;
  assign cmd_acc     = cmd_valid & cmd_ready;
  assign aw_hs       = awvalid_q & awready;
  assign w_hs        = wvalid_q & wready;
  assign wr_req_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_acc)     state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if (wr_req_done) state_d = S_WR_RESP;
      S_WR_RESP: if (bvalid)      state_d = S_RSP;
      S_RD_REQ:  if (arready)     state_d = S_RD_DATA;
      S_RD_DATA: if (rvalid)      state_d = S_RSP;
      S_RSP:     if (rsp_ready)   state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Next values of the registered AXI/rsp outputs, so every output is a flop.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (wr_req_done) bready_d = 1'b1;
      end
      S_WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
        end
      end
      S_RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
        end
      end
      S_RSP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule
